// File: rtl/plcp_receiver.sv
// 802.11 PLCP receiver: hunts the alternating preamble, checks SIGNAL, descrambles DATA and
// emits the PSDU bits with per-frame status pulses.
module plcp_receiver #(
   parameter int unsigned PREAMBLE_LEN = 96,
   parameter int unsigned N_DBPS       = 24,
   parameter int unsigned SERVICE_LEN  = 16,
   parameter int unsigned TAIL_LEN     = 6
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Input,
   input  logic        In_Valid,
   output logic        Output,
   output logic        Output_Valid,
   output logic [3:0]  Rate,
   output logic [11:0] Length,
   output logic        Signal_Valid,
   output logic        Signal_Error,
   output logic        Frame_Done,
   output logic        Busy
);
   localparam int unsigned RUN_W    = $clog2(PREAMBLE_LEN + 1);
   localparam int unsigned DBPS_W   = $clog2(N_DBPS + 1);
   localparam int unsigned CNT_W    = 15;
   localparam int unsigned SIG_W    = 18 + TAIL_LEN;
   localparam int unsigned SYNC_LEN = 7;

   typedef enum logic [3:0] {
      HUNT, SIG_RATE, SIG_RSVD, SIG_LEN, SIG_PAR, SIG_TAIL,
      DATA_SERVICE, DATA_PSDU, DATA_TAIL, DATA_PAD
   } state_t;

   state_t             state_q, state_d;
   logic [RUN_W-1:0]   run_q, run_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, psdu_last;
   logic [DBPS_W-1:0]  dbps_q, dbps_d, dbps_inc;
   logic               dbps_wrap;
   logic [SIG_W-2:0]   sig_q, sig_d;
   logic [SIG_W-1:0]   sig_word;
   logic [6:0]         lfsr_q, lfsr_d, lfsr_step;
   logic               scr_bit, sig_good;
   logic [3:0]         rate_d;
   logic [11:0]        length_d;
   logic               out_d, out_vld_d, sig_vld_d, sig_err_d, done_d, busy_d;

   // Descrambler history: lfsr_q[0] is b1 (newest), lfsr_q[6] is b7.
   assign scr_bit   = lfsr_q[6] ^ lfsr_q[3];
   assign lfsr_step = {lfsr_q[5:0], scr_bit};

   // SIGNAL word including the bit being accepted: RATE, rsvd, LENGTH, parity, tail (MSB first).
   assign sig_word  = {sig_q, Input};
   assign sig_good  = ~(^sig_word[SIG_W-1:TAIL_LEN])
                      && !sig_word[TAIL_LEN+13]
                      && (sig_word[TAIL_LEN-1:0] == '0)
                      && (sig_word[TAIL_LEN+1 +: 12] != '0);

   assign psdu_last = {Length, 3'b000} - CNT_W'(1);
   assign dbps_wrap = (dbps_q == DBPS_W'(N_DBPS - 1));
   assign dbps_inc  = dbps_wrap ? '0 : dbps_q + DBPS_W'(1);

   // Next-state, counters and registered-output values.
   always_comb begin
      state_d   = state_q;
      run_d     = run_q;
      cnt_d     = cnt_q;
      dbps_d    = dbps_q;
      sig_d     = sig_q;
      lfsr_d    = lfsr_q;
      rate_d    = Rate;
      length_d  = Length;
      out_d     = 1'b0;
      out_vld_d = 1'b0;
      sig_vld_d = 1'b0;
      sig_err_d = 1'b0;
      done_d    = 1'b0;

      if (In_Valid) begin
         cnt_d = cnt_q + CNT_W'(1);
         unique case (state_q)
            HUNT: begin
               cnt_d = '0;
               // A run always starts on a 1, so even positions expect 1 and odd ones 0.
               if (Input == ~run_q[0]) begin
                  if (run_q == RUN_W'(PREAMBLE_LEN - 1)) begin
                     run_d   = '0;
                     state_d = SIG_RATE;
                  end else begin
                     run_d = run_q + RUN_W'(1);
                  end
               end else begin
                  run_d = RUN_W'(Input);
               end
            end
            SIG_RATE: begin
               sig_d = sig_word[SIG_W-2:0];
               if (cnt_q == CNT_W'(3)) begin
                  cnt_d   = '0;
                  state_d = SIG_RSVD;
               end
            end
            SIG_RSVD: begin
               sig_d   = sig_word[SIG_W-2:0];
               cnt_d   = '0;
               state_d = SIG_LEN;
            end
            SIG_LEN: begin
               sig_d = sig_word[SIG_W-2:0];
               if (cnt_q == CNT_W'(11)) begin
                  cnt_d   = '0;
                  state_d = SIG_PAR;
               end
            end
            SIG_PAR: begin
               sig_d   = sig_word[SIG_W-2:0];
               cnt_d   = '0;
               state_d = SIG_TAIL;
            end
            SIG_TAIL: begin
               sig_d = sig_word[SIG_W-2:0];
               if (cnt_q == CNT_W'(TAIL_LEN - 1)) begin
                  cnt_d = '0;
                  if (sig_good) begin
                     rate_d    = sig_word[SIG_W-1 -: 4];
                     length_d  = sig_word[TAIL_LEN+1 +: 12];
                     sig_vld_d = 1'b1;
                     dbps_d    = '0;
                     state_d   = DATA_SERVICE;
                  end else begin
                     sig_err_d = 1'b1;
                     run_d     = '0;
                     state_d   = HUNT;
                  end
               end
            end
            DATA_SERVICE: begin
               dbps_d = dbps_inc;
               // The scrambler-sync bits are the raw sequence; later bits are descrambled.
               lfsr_d = (cnt_q < CNT_W'(SYNC_LEN)) ? {lfsr_q[5:0], Input} : lfsr_step;
               if (cnt_q == CNT_W'(SERVICE_LEN - 1)) begin
                  cnt_d   = '0;
                  state_d = DATA_PSDU;
               end
            end
            DATA_PSDU: begin
               dbps_d    = dbps_inc;
               lfsr_d    = lfsr_step;
               out_d     = Input ^ scr_bit;
               out_vld_d = 1'b1;
               if (cnt_q == psdu_last) begin
                  cnt_d   = '0;
                  state_d = DATA_TAIL;
               end
            end
            DATA_TAIL: begin
               dbps_d = dbps_inc;
               lfsr_d = lfsr_step;
               if (cnt_q == CNT_W'(TAIL_LEN - 1)) begin
                  cnt_d = '0;
                  if (dbps_wrap) begin
                     done_d  = 1'b1;
                     run_d   = '0;
                     state_d = HUNT;
                  end else begin
                     state_d = DATA_PAD;
                  end
               end
            end
            DATA_PAD: begin
               dbps_d = dbps_inc;
               lfsr_d = lfsr_step;
               if (dbps_wrap) begin
                  cnt_d   = '0;
                  done_d  = 1'b1;
                  run_d   = '0;
                  state_d = HUNT;
               end
            end
            default: begin
               cnt_d   = '0;
               run_d   = '0;
               state_d = HUNT;
            end
         endcase
      end

      busy_d = (state_d != HUNT);
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q      <= HUNT;
         run_q        <= '0;
         cnt_q        <= '0;
         dbps_q       <= '0;
         sig_q        <= '0;
         lfsr_q       <= '0;
         Rate         <= '0;
         Length       <= '0;
         Output       <= 1'b0;
         Output_Valid <= 1'b0;
         Signal_Valid <= 1'b0;
         Signal_Error <= 1'b0;
         Frame_Done   <= 1'b0;
         Busy         <= 1'b0;
      end else begin
         state_q      <= state_d;
         run_q        <= run_d;
         cnt_q        <= cnt_d;
         dbps_q       <= dbps_d;
         sig_q        <= sig_d;
         lfsr_q       <= lfsr_d;
         Rate         <= rate_d;
         Length       <= length_d;
         Output       <= out_d;
         Output_Valid <= out_vld_d;
         Signal_Valid <= sig_vld_d;
         Signal_Error <= sig_err_d;
         Frame_Done   <= done_d;
         Busy         <= busy_d;
      end
   end

endmodule

// File: tb/tb_plcp_receiver.sv
// Self-checking bench for plcp_receiver: frames are built from the field layout, scrambled with
// the x^7+x^4+1 recurrence, and every output is compared each cycle against the per-bit expectation.
module tb_plcp_receiver;
   localparam int PRE_LEN = 96;
   localparam int NDBPS   = 24;
   localparam int SVC_LEN = 16;
   localparam int TAIL    = 6;

   typedef struct packed {
      logic        o;
      logic        ov;
      logic        sv;
      logic        se;
      logic        fd;
      logic        busy;
      logic [3:0]  rate;
      logic [11:0] len;
   } exp_t;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Input;
   logic        In_Valid;
   logic        Output;
   logic        Output_Valid;
   logic [3:0]  Rate;
   logic [11:0] Length;
   logic        Signal_Valid;
   logic        Signal_Error;
   logic        Frame_Done;
   logic        Busy;

   plcp_receiver dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .Input        (Input),
      .In_Valid     (In_Valid),
      .Output       (Output),
      .Output_Valid (Output_Valid),
      .Rate         (Rate),
      .Length       (Length),
      .Signal_Valid (Signal_Valid),
      .Signal_Error (Signal_Error),
      .Frame_Done   (Frame_Done),
      .Busy         (Busy)
   );

   always #5 Clock = ~Clock;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          ov_seen  = 0;
   int          sv_seen  = 0;
   int          se_seen  = 0;
   int          fd_seen  = 0;
   bit          checking = 1'b0;
   exp_t        exp_next;
   logic        acc_next;
   exp_t        cur;
   logic [3:0]  m_rate;
   logic [11:0] m_len;
   logic        fbits[$];
   exp_t        fexp[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Expected outputs after each accepted bit; idle cycles keep levels and clear strobes.
   initial begin : compare
      cur = '0;
      forever begin
         @(posedge Clock);
         if (Reset) begin
            cur = '0;
         end else if (acc_next) begin
            cur = exp_next;
         end else begin
            cur.o  = 1'b0;
            cur.ov = 1'b0;
            cur.sv = 1'b0;
            cur.se = 1'b0;
            cur.fd = 1'b0;
         end
         #1;
         if (checking) begin
            if (Output_Valid === 1'b1) ov_seen++;
            if (Signal_Valid === 1'b1) sv_seen++;
            if (Signal_Error === 1'b1) se_seen++;
            if (Frame_Done === 1'b1)   fd_seen++;
            check("Output_Valid", 32'(Output_Valid), 32'(cur.ov));
            if (cur.ov) check("Output", 32'(Output), 32'(cur.o));
            check("Signal_Valid", 32'(Signal_Valid), 32'(cur.sv));
            check("Signal_Error", 32'(Signal_Error), 32'(cur.se));
            check("Frame_Done", 32'(Frame_Done), 32'(cur.fd));
            check("Busy", 32'(Busy), 32'(cur.busy));
            check("Rate", 32'(Rate), 32'(cur.rate));
            check("Length", 32'(Length), 32'(cur.len));
         end
      end
   end

   // err_kind: 0 good, 1 parity flipped, 2 rsvd set, 3 tail nonzero, 4 LENGTH zero.
   task automatic build_frame(input logic [3:0] rate, input logic [11:0] len,
                              input logic [6:0] seed, input int err_kind);
      logic [23:0] w;
      logic [11:0] lenf;
      logic        rsvd, par, good, d, s, in_psdu;
      logic        psdu[$];
      logic        seq[$];
      int          npsdu, ndata;
      exp_t        e;
      fbits.delete();
      fexp.delete();
      lenf = (err_kind == 4) ? 12'h000 : len;
      rsvd = (err_kind == 2);
      par  = (^rate) ^ rsvd ^ (^lenf);
      if (err_kind == 1) par = ~par;
      w    = {rate, rsvd, lenf, par, (err_kind == 3) ? 6'b001000 : 6'b000000};
      good = (err_kind == 0) && (lenf != 12'h000);
      e = '0;
      e.rate = m_rate;
      e.len  = m_len;
      for (int i = 0; i < PRE_LEN; i++) begin
         e.busy = (i == PRE_LEN - 1);
         fbits.push_back(1'(i % 2 == 0));
         fexp.push_back(e);
      end
      for (int i = 0; i < 24; i++) begin
         e.busy = 1'b1;
         if (i == 23) begin
            if (good) begin
               e.sv   = 1'b1;
               e.rate = rate;
               e.len  = lenf;
            end else begin
               e.se   = 1'b1;
               e.busy = 1'b0;
            end
         end
         fbits.push_back(w[23-i]);
         fexp.push_back(e);
      end
      if (good) begin
         m_rate = rate;
         m_len  = lenf;
         npsdu  = 8 * int'(lenf);
         ndata  = SVC_LEN + npsdu + TAIL;
         ndata  = ((ndata + NDBPS - 1) / NDBPS) * NDBPS;
         for (int k = 0; k < npsdu; k++) psdu.push_back(1'($urandom_range(1)));
         for (int k = 0; k < 7; k++) seq.push_back(seed[6-k]);
         for (int k = 0; k < ndata; k++) begin
            in_psdu = (k >= SVC_LEN) && (k < SVC_LEN + npsdu);
            d = in_psdu ? psdu[k-SVC_LEN] : 1'b0;
            s = seq[seq.size()-7] ^ seq[seq.size()-4];
            seq.push_back(s);
            e = '0;
            e.rate = m_rate;
            e.len  = m_len;
            e.ov   = in_psdu;
            e.o    = in_psdu ? d : 1'b0;
            e.fd   = (k == ndata - 1);
            e.busy = (k != ndata - 1);
            fbits.push_back(d ^ s);
            fexp.push_back(e);
         end
      end
   endtask

   task automatic drive_bit(input logic b, input exp_t e, input int gap_pct);
      while (int'($urandom_range(99)) < gap_pct) begin
         @(negedge Clock);
         Input    = 1'($urandom_range(1));
         In_Valid = 1'b0;
         acc_next = 1'b0;
      end
      @(negedge Clock);
      Input    = b;
      In_Valid = 1'b1;
      acc_next = 1'b1;
      exp_next = e;
   endtask

   task automatic send_frame(input int nmax, input int gap_pct);
      for (int i = 0; i < fbits.size() && i < nmax; i++) drive_bit(fbits[i], fexp[i], gap_pct);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge Clock);
         Input    = 1'($urandom_range(1));
         In_Valid = 1'b0;
         acc_next = 1'b0;
      end
   endtask

   task automatic hunt_bit(input logic b);
      exp_t e;
      e = '0;
      e.rate = m_rate;
      e.len  = m_len;
      drive_bit(b, e, 0);
   endtask

   task automatic do_reset();
      @(negedge Clock);
      Reset    = 1'b1;
      In_Valid = 1'b0;
      acc_next = 1'b0;
      m_rate   = '0;
      m_len    = '0;
      @(negedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
   endtask

   initial begin : main
      int ov0, sv0, se0, fd0, len_r, err_r;
      logic [3:0] rate_r;
      Reset    = 1'b1;
      Input    = 1'b0;
      In_Valid = 1'b0;
      acc_next = 1'b0;
      exp_next = '0;
      m_rate   = '0;
      m_len    = '0;
      repeat (3) @(negedge Clock);
      check("reset_Output_Valid", 32'(Output_Valid), 32'd0);
      check("reset_Busy", 32'(Busy), 32'd0);
      check("reset_Rate", 32'(Rate), 32'd0);
      check("reset_Length", 32'(Length), 32'd0);
      Reset    = 1'b0;
      checking = 1'b1;
      idle(2);

      // Reference frame: RATE=1101, LENGTH=0x010, seed 0x5D.
      ov0 = ov_seen; sv0 = sv_seen; fd0 = fd_seen;
      build_frame(4'hD, 12'h010, 7'h5D, 0);
      check("t2_frame_bits", 32'(fbits.size()), 32'd288);
      send_frame(1 << 30, 0);
      idle(3);
      check("t1_rate", 32'(Rate), 32'hD);
      check("t1_length", 32'(Length), 32'h010);
      check("t1_signal_valid_count", 32'(sv_seen - sv0), 32'd1);
      check("t2_psdu_strobes", 32'(ov_seen - ov0), 32'd128);
      check("t2_frame_done_count", 32'(fd_seen - fd0), 32'd1);

      // Bad parity on a different RATE/LENGTH: old values must survive.
      ov0 = ov_seen; se0 = se_seen;
      build_frame(4'hB, 12'h020, 7'h5D, 1);
      send_frame(1 << 30, 0);
      idle(2);
      check("t3_signal_error_count", 32'(se_seen - se0), 32'd1);
      check("t3_no_strobes", 32'(ov_seen - ov0), 32'd0);
      check("t3_rate_kept", 32'(Rate), 32'hD);
      check("t3_length_kept", 32'(Length), 32'h010);
      check("t3_busy", 32'(Busy), 32'd0);

      // 40 alternating bits, then a '11' break, then a full frame.
      for (int i = 0; i < 40; i++) hunt_bit(1'(i % 2 == 0));
      hunt_bit(1'b1);
      hunt_bit(1'b1);
      ov0 = ov_seen; fd0 = fd_seen;
      build_frame(4'h5, 12'h003, 7'h11, 0);
      send_frame(1 << 30, 0);
      idle(3);
      check("t4_rate", 32'(Rate), 32'h5);
      check("t4_psdu_strobes", 32'(ov_seen - ov0), 32'd24);
      check("t4_frame_done_count", 32'(fd_seen - fd0), 32'd1);

      // Reference frame again with random In_Valid gaps.
      ov0 = ov_seen; fd0 = fd_seen;
      build_frame(4'hD, 12'h010, 7'h5D, 0);
      send_frame(1 << 30, 35);
      idle(3);
      check("t5_psdu_strobes", 32'(ov_seen - ov0), 32'd128);
      check("t5_frame_done_count", 32'(fd_seen - fd0), 32'd1);

      // Reset in mid-PSDU, then a one-byte frame.
      build_frame(4'hD, 12'h010, 7'h5D, 0);
      send_frame(200, 0);
      do_reset();
      check("t6_rate_after_reset", 32'(Rate), 32'd0);
      ov0 = ov_seen; fd0 = fd_seen;
      build_frame(4'h9, 12'h001, 7'h2A, 0);
      check("t6_frame_bits", 32'(fbits.size()), 32'd168);
      send_frame(1 << 30, 10);
      idle(3);
      check("t6_psdu_strobes", 32'(ov_seen - ov0), 32'd8);
      check("t6_frame_done_count", 32'(fd_seen - fd0), 32'd1);

      // Randomised frames, some with corrupted SIGNAL fields.
      for (int f = 0; f < 12; f++) begin
         rate_r = 4'($urandom_range(15));
         len_r  = int'($urandom_range(1, 24));
         err_r  = ($urandom_range(3) == 0) ? int'($urandom_range(1, 4)) : 0;
         for (int z = 0; z < int'($urandom_range(5)); z++) hunt_bit(1'b0);
         ov0 = ov_seen; fd0 = fd_seen; se0 = se_seen;
         build_frame(rate_r, 12'(len_r), 7'($urandom_range(1, 127)), err_r);
         send_frame(1 << 30, int'($urandom_range(40)));
         idle(3);
         check("rnd_psdu_strobes", 32'(ov_seen - ov0), (err_r == 0) ? 32'(8 * len_r) : 32'd0);
         check("rnd_frame_done", 32'(fd_seen - fd0), (err_r == 0) ? 32'd1 : 32'd0);
         check("rnd_signal_error", 32'(se_seen - se0), (err_r == 0) ? 32'd0 : 32'd1);
      end

      checking = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
